// File: rtl/csa_serial_add_ctrl_if.sv
// Operand request and result handshake bundle
// for the nibble-serial carry-select adder controller.
interface csa_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
    input  out_valid,
    output out_ready,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
    output out_valid,
    input  out_ready,
    output sum,
    output cout
  );
endinterface

// File: rtl/csa_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle
// through a single shared 4-bit carry-select slice.
module csa_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  csa_serial_add_ctrl_if.slave  bus,
  output logic                  busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [IW-1:0]    idx;

  logic             acc;
  logic             rel;
  logic             last;
  logic [3:0]       an;
  logic [3:0]       bn;
  logic [4:0]       r0;
  logic [4:0]       r1;
  logic [4:0]       rs;

  assign acc  = bus.in_valid && (state == IDLE);
  assign rel  = bus.out_ready && (state == DONE);
  assign last = (idx == IW'(NIB - 1));

  always_comb begin
    an = '0;
    bn = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        an = a_r[4*i +: 4];
        bn = b_r[4*i +: 4];
      end
    end
  end

  // Both carry candidates are formed up front;
  // carry_r only steers the final mux.
  assign r0 = {1'b0, an} + {1'b0, bn};
  assign r1 = {1'b0, an} + {1'b0, bn} + 5'd1;
  assign rs = carry_r ? r1 : r0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (acc)  state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (rel)  state_n = IDLE;
      default:        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.cin;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            idx     <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) begin
              sum_r[4*i +: 4] <= rs[3:0];
            end
          end
          carry_r <= rs[4];
          if (last) begin
            cout_r <= rs[4];
            idx    <= '0;
          end else begin
            idx    <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Bench for csa_serial_add_ctrl: vector table,
// scoreboard queue and multi-cycle corner sequences.
module tb_csa_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk;
  logic rst;
  logic busy;

  csa_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  csa_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] esum;
    logic         ecout;
    int           bp;
  } vec_t;

  vec_t        vt[9];
  logic [W:0]  exp_q[$];
  int          checks;
  int          failures;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  task automatic scramble();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
  endtask

  // Entered and left at a negedge.
  task automatic run_op(input logic [W-1:0] va,
                        input logic [W-1:0] vb,
                        input logic         vc,
                        input logic [W-1:0] es,
                        input logic         ec,
                        input int           bp,
                        input bit           scr);
    logic [W:0]   e;
    logic [W-1:0] hs;
    logic         hc;
    int           lat;
    int           w;
    bus.a        = va;
    bus.b        = vb;
    bus.cin      = vc;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_req", 32'(bus.in_ready), 32'd1);
    exp_q.push_back({ec, es});
    @(negedge clk);
    bus.in_valid = scr;
    if (scr) scramble();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (scr) scramble();
    end
    chk("latency", 32'(lat), 32'(NIB));
    bus.in_valid = 1'b0;
    hs = bus.sum;
    hc = bus.cout;
    if (bp > 0) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'hABCD;
      bus.b        = 16'h1234;
      bus.cin      = 1'b0;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_sum", 32'(bus.sum), 32'(hs));
      chk("bp_cout", 32'(bus.cout), 32'(hc));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    chk("out_valid_hs", 32'(bus.out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sum", 32'(bus.sum), 32'(e[W-1:0]));
      chk("cout", 32'(bus.cout), 32'(e[W]));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [W:0]   m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    checks   = 0;
    failures = 0;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
    vt[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3};
    vt[4] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 0};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
    vt[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0};
    vt[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 0};
    vt[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};

    rst           = 1'b1;
    bus.in_valid  = 1'($urandom);
    bus.out_ready = 1'($urandom);
    scramble();
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      bus.in_valid = 1'($urandom);
      scramble();
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin,
             vt[i].esum, vt[i].ecout, vt[i].bp, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      m  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(ra, rb, rc, m[W-1:0], m[W], 0, 1'b1);
    end

    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_sum", 32'(bus.sum), 32'd0);
    chk("mid_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_pulse", 32'(bus.out_valid), 32'd0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 1'b0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
